// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank controller: register map and synchroniser depth.
package gpio_bank_pkg;

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_OE         = 3'd1;
  localparam logic [2:0] ADDR_INP_EN     = 3'd2;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd3;
  localparam logic [2:0] ADDR_DEB_EN     = 3'd4;
  localparam logic [2:0] ADDR_RISE_EN    = 3'd5;
  localparam logic [2:0] ADDR_FALL_EN    = 3'd6;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd7;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input pin: synchroniser, optional debounce, filtered level and
// unmasked rise/fall events derived from the next filtered level.
module gpio_in_filter
  import gpio_bank_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = $clog2(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  input  logic inp_en,
  input  logic deb_en,
  output logic filt,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   deb_en_q;
  logic                   s2;

  assign s2 = sync_q[SYNC_STAGES-1];

  // Next-state for synchroniser, filtered level and debounce counter.
  always_comb begin
    sync_d = '0;
    filt_d = filt_q;
    cnt_d  = '0;
    if (inp_en) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
      if (!deb_en) begin
        filt_d = s2;
      end else if (s2 == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        filt_d = s2;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Disabled pins are parked at 0 so re-enabling starts from a known level.
      filt_d = 1'b0;
    end
    // A debounce mode change restarts any count in progress.
    if (deb_en != deb_en_q) begin
      cnt_d = '0;
    end
  end

  // Edge events fire on the same edge the filtered level changes.
  always_comb begin
    rise = inp_en & ~filt_q &  filt_d;
    fall = inp_en &  filt_q & ~filt_d;
  end

  assign filt = filt_q;

  // Input-path state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      filt_q   <= 1'b0;
      cnt_q    <= '0;
      deb_en_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      deb_en_q <= deb_en;
    end
  end

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Register-controlled GPIO bank: pad drive control, filtered inputs and
// sticky edge interrupt status behind a simple strobe register bus.
module gpio_bank_ctrl
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = $clog2(DEB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             irq,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe_n,
  output logic [WIDTH-1:0] pad_inp_dis
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] inp_en_q, inp_en_d;
  logic [WIDTH-1:0] deb_en_q, deb_en_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] filt, rise_raw, fall_raw;
  logic [WIDTH-1:0] w1c_mask;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_filter #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .pad_in(pad_in[i]),
      .inp_en(inp_en_q[i]),
      .deb_en(deb_en_q[i]),
      .filt  (filt[i]),
      .rise  (rise_raw[i]),
      .fall  (fall_raw[i])
    );
  end

  // Register writes, W1C status update (set wins over clear) and read mux.
  always_comb begin
    data_out_d = data_out_q;
    oe_d       = oe_q;
    inp_en_d   = inp_en_q;
    deb_en_d   = deb_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c_mask   = '0;
    if (wr_en) begin
      case (addr)
        ADDR_DATA_OUT:   data_out_d = wdata;
        ADDR_OE:         oe_d       = wdata;
        ADDR_INP_EN:     inp_en_d   = wdata;
        ADDR_DEB_EN:     deb_en_d   = wdata;
        ADDR_RISE_EN:    rise_en_d  = wdata;
        ADDR_FALL_EN:    fall_en_d  = wdata;
        ADDR_IRQ_STATUS: w1c_mask   = wdata;
        default:         ;
      endcase
    end
    irq_status_d = (irq_status_q & ~w1c_mask)
                 | (rise_raw & rise_en_q)
                 | (fall_raw & fall_en_q);

    rdata_d  = rdata_q;
    rvalid_d = rd_en;
    if (rd_en) begin
      case (addr)
        ADDR_DATA_OUT:   rdata_d = data_out_q;
        ADDR_OE:         rdata_d = oe_q;
        ADDR_INP_EN:     rdata_d = inp_en_q;
        ADDR_DATA_IN:    rdata_d = filt;
        ADDR_DEB_EN:     rdata_d = deb_en_q;
        ADDR_RISE_EN:    rdata_d = rise_en_q;
        ADDR_FALL_EN:    rdata_d = fall_en_q;
        default:         rdata_d = irq_status_q;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      oe_q         <= '0;
      inp_en_q     <= '0;
      deb_en_q     <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      oe_q         <= oe_d;
      inp_en_q     <= inp_en_d;
      deb_en_q     <= deb_en_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_status_q <= irq_status_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign pad_out     = data_out_q;
  assign pad_oe_n    = ~oe_q;
  assign pad_inp_dis = ~inp_en_q;
  assign irq         = |irq_status_q;
  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl (WIDTH=8, DEB_CYCLES=16).
module tb_gpio_bank_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic       irq;
  logic [7:0] pad_in;
  logic [7:0] pad_out;
  logic [7:0] pad_oe_n;
  logic [7:0] pad_inp_dis;

  int total = 0;
  int bad   = 0;

  gpio_bank_ctrl #(.WIDTH(8), .DEB_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .irq        (irq),
    .pad_in     (pad_in),
    .pad_out    (pad_out),
    .pad_oe_n   (pad_oe_n),
    .pad_inp_dis(pad_inp_dis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [7:0] d,
                         output logic v1, output logic v2);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    d     = rdata;
    v1    = rvalid;
    rd_en = 1'b0;
    @(negedge clk);
    v2    = rvalid;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic v1, v2;
    do_write(3'd1, 8'hFF);
    do_write(3'd0, 8'hFF);
    do_write(3'd2, 8'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pad_oe_n !== 8'hFF) begin bad++; $display("FAIL rst_oe_n got=%h exp=ff", pad_oe_n); end
    total++;
    if (pad_inp_dis !== 8'hFF) begin bad++; $display("FAIL rst_inp_dis got=%h exp=ff", pad_inp_dis); end
    total++;
    if (pad_out !== 8'h00) begin bad++; $display("FAIL rst_pad_out got=%h exp=00", pad_out); end
    total++;
    if (irq !== 1'b0 || rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_irq_rvalid got=%b%b exp=00", irq, rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), d, v1, v2);
      total++;
      if (d !== 8'h00 || v1 !== 1'b1) begin
        bad++; $display("FAIL rst_read addr=%0d got=%h/%b exp=00/1", a, d, v1);
      end
    end
    do_write(3'd3, 8'hFF);
    do_read(3'd3, d, v1, v2);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ro_data_in got=%h exp=00", d); end
  endtask

  task automatic test_output_drive();
    logic [7:0] d;
    logic v1, v2;
    do_write(3'd1, 8'h0F);
    total++;
    if (pad_oe_n !== 8'hF0) begin bad++; $display("FAIL oe_n got=%h exp=f0", pad_oe_n); end
    do_write(3'd0, 8'hA5);
    total++;
    if (pad_out !== 8'hA5) begin bad++; $display("FAIL pad_out got=%h exp=a5", pad_out); end
    do_read(3'd0, d, v1, v2);
    total++;
    if (d !== 8'hA5 || v1 !== 1'b1 || v2 !== 1'b0) begin
      bad++; $display("FAIL read_data_out got=%h/%b%b exp=a5/10", d, v1, v2);
    end
    // Simultaneous read and write of the same register returns the old value.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd0; wdata = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (rdata !== 8'hA5 || pad_out !== 8'h3C) begin
      bad++; $display("FAIL rw_same_cycle got=%h/%h exp=a5/3c", rdata, pad_out);
    end
    repeat (3) @(negedge clk);
    total++;
    if (rdata !== 8'hA5) begin bad++; $display("FAIL rdata_hold got=%h exp=a5", rdata); end
  endtask

  task automatic test_input_sync();
    logic [7:0] d;
    logic v1, v2;
    do_write(3'd2, 8'h01);
    do_write(3'd5, 8'h01);
    pad_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL sync_early got=%b exp=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL sync_irq got=%b exp=1", irq); end
    do_read(3'd3, d, v1, v2);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL sync_data_in got=%h exp=01", d); end
    do_read(3'd7, d, v1, v2);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL sync_status got=%h exp=01", d); end
    do_write(3'd7, 8'h01);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL sync_clear got=%b exp=0", irq); end
  endtask

  task automatic test_debounce();
    logic [7:0] d;
    logic v1, v2;
    do_write(3'd2, 8'h03);
    do_write(3'd5, 8'h02);
    do_write(3'd4, 8'h02);
    pad_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    pad_in[1] = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL deb_glitch_irq got=%b exp=0", irq); end
    do_read(3'd3, d, v1, v2);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL deb_glitch_data got=%h exp=01", d); end
    pad_in[1] = 1'b1;
    repeat (17) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL deb_early got=%b exp=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL deb_accept got=%b exp=1", irq); end
    do_read(3'd3, d, v1, v2);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL deb_data got=%h exp=03", d); end
    do_write(3'd7, 8'h02);
  endtask

  task automatic test_w1c_race();
    logic [7:0] d;
    logic v1, v2;
    do_write(3'd2, 8'h07);
    pad_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    do_write(3'd6, 8'h04);
    pad_in[2] = 1'b0;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; addr = 3'd7; wdata = 8'h04;
    @(negedge clk);
    wr_en = 1'b0;
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL race_irq got=%b exp=1", irq); end
    do_read(3'd7, d, v1, v2);
    total++;
    if (d !== 8'h04) begin bad++; $display("FAIL race_status got=%h exp=04", d); end
    do_write(3'd7, 8'h04);
    do_read(3'd7, d, v1, v2);
    total++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      bad++; $display("FAIL race_clear got=%h/%b exp=00/0", d, irq);
    end
  endtask

  task automatic test_input_disable();
    logic [7:0] d;
    logic v1, v2;
    pad_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (pad_inp_dis !== 8'hF8) begin bad++; $display("FAIL dis_inp_dis got=%h exp=f8", pad_inp_dis); end
    do_read(3'd3, d, v1, v2);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL dis_data_in got=%h exp=03", d); end
    do_read(3'd7, d, v1, v2);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL dis_status got=%h exp=00", d); end
    do_write(3'd5, 8'h08);
    do_write(3'd2, 8'h0F);
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL en_early got=%b exp=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL en_rise got=%b exp=1", irq); end
    do_read(3'd7, d, v1, v2);
    total++;
    if (d !== 8'h08) begin bad++; $display("FAIL en_status got=%h exp=08", d); end
  endtask

  initial begin
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    addr   = 3'd0;
    wdata  = 8'h00;
    pad_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_output_drive();
    test_input_sync();
    test_debounce();
    test_w1c_race();
    test_input_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
